rv_core_ibex_mem_lat_shim: RTL and testbench
============================================

// Module: rv_core_ibex_mem_lat_shim
// PURPOSE
// - Sits between the SRAM-side ports of the core's TL-UL SRAM adapters and the external memory model.
// - Replaces the hard-wired 1-cycle rvalid register with a parametrised per-channel response engine.
// - Features: N channels, configurable fixed read latency or memory-driven variable latency,
//   an outstanding-read limit, and out-of-range read error responses.
// - ReadLatency=1, LatMode=LAT_FIXED reproduces today's instr/data behaviour exactly.
// PARAMETERS
// - NumChan         2        number of independent channels (0=instr, 1=data, ...)
// - AddrW           18       word address width
// - DataW           32       data/mask width
// - MemWords        1<<18    valid word range; addr_i >= MemWords is out-of-range (OOR)
// - LatMode         LAT_FIXED  LAT_FIXED: shim times responses; LAT_VAR: mem_rvalid_i times them
// - ReadLatency     1        cycles from accepted read to rvalid_o (LAT_FIXED); >=1
// - MaxOutstanding  2        max in-flight reads per channel; >=1; counter width $clog2(MaxOutstanding+1)
// PORTS
// - clk_i          in   1               clock
// - rst_ni         in   1               reset, asynchronous, active-low
// - req_i          in   NumChan         adapter request
// - gnt_o          out  NumChan         request accepted this cycle
// - we_i           in   NumChan         1=write
// - addr_i         in   NumChan x AddrW word address
// - wdata_i        in   NumChan x DataW write data
// - wmask_i        in   NumChan x DataW bit write mask
// - rdata_o        out  NumChan x DataW read data, valid with rvalid_o
// - rvalid_o       out  NumChan         read response strobe
// - rerror_o       out  NumChan x 2     2'b10 on OOR read, else 2'b00
// - mem_req_o / mem_gnt_i / mem_we_o / mem_addr_o / mem_wdata_o / mem_wmask_o   per-channel memory request
// - mem_rdata_i    in   NumChan x DataW memory read data
// - mem_rvalid_i   in   NumChan         memory response strobe (ignored in LAT_FIXED)
// - err_o          out  NumChan         sticky protocol error (unexpected mem_rvalid_i)
// BEHAVIOUR
// - Reset (async): pipes, counters, err_o cleared; gnt_o, rvalid_o, mem_req_o=0; rdata_o='0; rerror_o=0.
// - can_rd = (cnt < MaxOutstanding) & (LAT_FIXED | ~oor_busy).
// - In-range request: mem_req_o = req_i & (we_i | can_rd); gnt_o = mem_req_o & mem_gnt_i.
//   Other mem_* outputs pass through combinationally.
// - OOR request: never reaches memory (mem_req_o=0).
//   - OOR write: gnt_o=1 same cycle, dropped silently, no response.
//   - OOR read: gnt_o=can_rd; LAT_VAR additionally requires cnt==0.
// - Writes: never produce rvalid_o and never count against the outstanding limit.
// - LAT_FIXED: accepted read enters a ReadLatency-deep shift pipe {valid,oor}; back-to-back accepts allowed.
//   - At pipe exit: rvalid_o=1; rdata_o = oor ? '0 : mem_rdata_i; rerror_o = oor ? 2'b10 : 0.
//   - A read accepted at cycle t responds at t+ReadLatency.
// - LAT_VAR: real read responds in the cycle mem_rvalid_i=1 (rdata_o=mem_rdata_i).
//   - OOR read responds the cycle after gnt_o; oor_busy is set until then, blocking further reads.
// - cnt: +1 on read accept, -1 on response; simultaneous accept+response leaves it unchanged; never wraps.
// - mem_rvalid_i with cnt==0 (LAT_VAR): response ignored, err_o set until reset.
// - Reset mid-operation: in-flight responses are discarded; nothing is emitted after reset release.
// - Channels are fully independent; there is no cross-channel arbitration.
// STRUCTURE
// - Package rv_core_ibex_mem_shim_pkg: lat_mode_e {LAT_FIXED, LAT_VAR}; RERR_NONE=2'b00, RERR_OOR=2'b10.
// - Sub-module rv_core_ibex_mem_lat_chan: one channel (pipe, counter, OOR logic).
//   Top level = generate loop over NumChan plus port slicing.
// - Assertions: cnt<=MaxOutstanding; rvalid_o never on a cycle without an owed read;
//   ReadLatency>=1 (elaboration check).
// TESTING
// - Default params, ch0 read addr 0x10 at t, mem_rdata_i=0xDEADBEEF -> rvalid_o at t+1, rdata_o=0xDEADBEEF, rerror_o=0.
// - ReadLatency=3, MaxOutstanding=2, reads each cycle t..t+3 -> gnt_o=1 at t,t+1; 0 at t+2;
//   rvalid_o at t+3,t+4; accepts resume per freed credit.
// - Read addr=MemWords -> mem_req_o=0, rvalid_o after ReadLatency, rdata_o=0, rerror_o=2'b10; OOR write -> gnt_o=1, no rvalid.
// - LAT_VAR, 2 reads outstanding, mem_rvalid_i at t+5 and t+9 -> rvalid_o same cycles;
//   third mem_rvalid_i -> err_o=1, stays 1.
// - LAT_VAR, OOR read requested while cnt=1 -> gnt_o=0 until the response arrives; then granted, rvalid_o next cycle.
// - rst_ni low with 2 reads in pipe, release -> no rvalid_o, cnt=0, a new read completes with the nominal latency.

Source files
------------

// File: rtl/rv_core_ibex_mem_shim_pkg.sv
// rv_core_ibex_mem_shim_pkg: shared types and constants for the memory latency shim
package rv_core_ibex_mem_shim_pkg;
   typedef enum logic {LAT_FIXED, LAT_VAR} lat_mode_e;
   localparam logic [1:0] RERR_NONE = 2'b00;
   localparam logic [1:0] RERR_OOR  = 2'b10;
endpackage

// File: rtl/rv_core_ibex_mem_lat_chan.sv
// rv_core_ibex_mem_lat_chan: one shim channel (response pipe, credit counter, out-of-range handling)
module rv_core_ibex_mem_lat_chan
   import rv_core_ibex_mem_shim_pkg::*;
#(
   parameter int        AddrW          = 18,
   parameter int        DataW          = 32,
   parameter int        MemWords       = 1 << 18,
   parameter lat_mode_e LatMode        = LAT_FIXED,
   parameter int        ReadLatency    = 1,
   parameter int        MaxOutstanding = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic             we_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic [DataW-1:0] wmask_i,
   output logic [DataW-1:0] rdata_o,
   output logic             rvalid_o,
   output logic [1:0]       rerror_o,
   output logic             mem_req_o,
   input  logic             mem_gnt_i,
   output logic             mem_we_o,
   output logic [AddrW-1:0] mem_addr_o,
   output logic [DataW-1:0] mem_wdata_o,
   output logic [DataW-1:0] mem_wmask_o,
   input  logic [DataW-1:0] mem_rdata_i,
   input  logic             mem_rvalid_i,
   output logic             err_o
);
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam bit IsVar = (LatMode == LAT_VAR);
   localparam logic [AddrW:0] MemLim = (AddrW + 1)'(MemWords);

   if (ReadLatency < 1) begin : g_bad_lat
      $error("ReadLatency must be at least 1");
   end

   logic oor, can_rd, rd_acc, oor_pend, mem_rsp, rsp, fix_oor;
   logic [CntW-1:0] cnt;
   logic [ReadLatency-1:0] pipe_v, pipe_o;

   assign oor = {1'b0, addr_i} >= MemLim;
   assign can_rd = (cnt < CntW'(MaxOutstanding)) & (~IsVar | ~oor_pend);
   // Outputs are forced low while reset is held, even with req_i asserted.
   assign mem_req_o = rst_ni & req_i & ~oor & (we_i | can_rd);
   assign gnt_o = oor ? (rst_ni & req_i & (we_i | (can_rd & (~IsVar | (cnt == '0)))))
                      : (mem_req_o & mem_gnt_i);
   assign rd_acc = gnt_o & ~we_i;
   assign mem_we_o = we_i;
   assign mem_addr_o = addr_i;
   assign mem_wdata_o = wdata_i;
   assign mem_wmask_o = wmask_i;

   // While an OOR response is pending every credit belongs to it, so memory owes nothing.
   assign mem_rsp = mem_rvalid_i & ~oor_pend & (cnt != '0);
   assign fix_oor = pipe_o[ReadLatency-1];
   assign rsp = IsVar ? (mem_rsp | oor_pend) : pipe_v[ReadLatency-1];
   assign rvalid_o = rsp;
   assign rerror_o = (IsVar ? oor_pend : (rsp & fix_oor)) ? RERR_OOR : RERR_NONE;
   assign rdata_o = (IsVar ? mem_rsp : (rsp & ~fix_oor)) ? mem_rdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
         pipe_v <= '0;
         pipe_o <= '0;
         oor_pend <= 1'b0;
         err_o <= 1'b0;
      end else begin
         cnt <= cnt + CntW'(rd_acc) - CntW'(rsp);
         pipe_v <= (pipe_v << 1) | ReadLatency'(rd_acc & ~IsVar);
         pipe_o <= (pipe_o << 1) | ReadLatency'(oor);
         oor_pend <= IsVar & rd_acc & oor;
         err_o <= err_o | (IsVar & mem_rvalid_i & ~mem_rsp);
      end
   end

   a_cnt_lim: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt <= CntW'(MaxOutstanding));
   a_owed: assert property (@(posedge clk_i) disable iff (!rst_ni) rvalid_o |-> (cnt != '0));
endmodule

// File: rtl/rv_core_ibex_mem_lat_shim.sv
// rv_core_ibex_mem_lat_shim: per-channel response engine between the SRAM adapters and memory.
// Channels are independent; this level only slices the ports.
module rv_core_ibex_mem_lat_shim
   import rv_core_ibex_mem_shim_pkg::*;
#(
   parameter int        NumChan        = 2,
   parameter int        AddrW          = 18,
   parameter int        DataW          = 32,
   parameter int        MemWords       = 1 << 18,
   parameter lat_mode_e LatMode        = LAT_FIXED,
   parameter int        ReadLatency    = 1,
   parameter int        MaxOutstanding = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumChan-1:0]              req_i,
   output logic [NumChan-1:0]              gnt_o,
   input  logic [NumChan-1:0]              we_i,
   input  logic [NumChan-1:0][AddrW-1:0]   addr_i,
   input  logic [NumChan-1:0][DataW-1:0]   wdata_i,
   input  logic [NumChan-1:0][DataW-1:0]   wmask_i,
   output logic [NumChan-1:0][DataW-1:0]   rdata_o,
   output logic [NumChan-1:0]              rvalid_o,
   output logic [NumChan-1:0][1:0]         rerror_o,
   output logic [NumChan-1:0]              mem_req_o,
   input  logic [NumChan-1:0]              mem_gnt_i,
   output logic [NumChan-1:0]              mem_we_o,
   output logic [NumChan-1:0][AddrW-1:0]   mem_addr_o,
   output logic [NumChan-1:0][DataW-1:0]   mem_wdata_o,
   output logic [NumChan-1:0][DataW-1:0]   mem_wmask_o,
   input  logic [NumChan-1:0][DataW-1:0]   mem_rdata_i,
   input  logic [NumChan-1:0]              mem_rvalid_i,
   output logic [NumChan-1:0]              err_o
);
   for (genvar i = 0; i < NumChan; i++) begin : g_chan
      rv_core_ibex_mem_lat_chan #(
         .AddrW(AddrW), .DataW(DataW), .MemWords(MemWords), .LatMode(LatMode),
         .ReadLatency(ReadLatency), .MaxOutstanding(MaxOutstanding)
      ) u_chan (
         .clk_i(clk_i), .rst_ni(rst_ni),
         .req_i(req_i[i]), .gnt_o(gnt_o[i]), .we_i(we_i[i]), .addr_i(addr_i[i]),
         .wdata_i(wdata_i[i]), .wmask_i(wmask_i[i]),
         .rdata_o(rdata_o[i]), .rvalid_o(rvalid_o[i]), .rerror_o(rerror_o[i]),
         .mem_req_o(mem_req_o[i]), .mem_gnt_i(mem_gnt_i[i]), .mem_we_o(mem_we_o[i]),
         .mem_addr_o(mem_addr_o[i]), .mem_wdata_o(mem_wdata_o[i]), .mem_wmask_o(mem_wmask_o[i]),
         .mem_rdata_i(mem_rdata_i[i]), .mem_rvalid_i(mem_rvalid_i[i]), .err_o(err_o[i])
      );
   end
endmodule

// File: tb/tb_rv_core_ibex_mem_lat_shim.sv
// tb_rv_core_ibex_mem_lat_shim: randomized scoreboard bench over three shim configurations
// (default fixed/1-cycle, fixed/3-cycle with OOR range, variable latency with OOR range).
module tb_rv_core_ibex_mem_lat_shim;
   import rv_core_ibex_mem_shim_pkg::*;
   localparam int NI = 3, NC = 2, AW = 18, DW = 32, MO = 2;
   typedef struct {
      int             due;
      logic [DW-1:0]  data;
      logic [1:0]     err;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [NC-1:0] req [NI], gnt [NI], we [NI], rvalid [NI], mreq [NI], mgnt [NI], mwe [NI], mrvalid [NI], err [NI];
   logic [NC-1:0][AW-1:0] addr [NI], maddr [NI];
   logic [NC-1:0][DW-1:0] wdata [NI], wmask [NI], rdata [NI], mwdata [NI], mwmask [NI], mrdata [NI];
   logic [NC-1:0][1:0] rerror [NI];

   exp_t sb [NI][NC][$];
   int   fq [NI][NC][$];
   int   owed [NI][NC];
   bit   busy [NI][NC], err_exp [NI][NC], oor_in [NI][NC];
   int   cyc = 0, n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      rv_core_ibex_mem_lat_shim #(
         .NumChan(NC), .AddrW(AW), .DataW(DW), .MemWords(g == 0 ? (1 << 18) : 1000),
         .LatMode(g == 2 ? LAT_VAR : LAT_FIXED), .ReadLatency(g == 1 ? 3 : 1), .MaxOutstanding(MO)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .req_i(req[g]), .gnt_o(gnt[g]), .we_i(we[g]), .addr_i(addr[g]),
         .wdata_i(wdata[g]), .wmask_i(wmask[g]),
         .rdata_o(rdata[g]), .rvalid_o(rvalid[g]), .rerror_o(rerror[g]),
         .mem_req_o(mreq[g]), .mem_gnt_i(mgnt[g]), .mem_we_o(mwe[g]),
         .mem_addr_o(maddr[g]), .mem_wdata_o(mwdata[g]), .mem_wmask_o(mwmask[g]),
         .mem_rdata_i(mrdata[g]), .mem_rvalid_i(mrvalid[g]), .err_o(err[g])
      );
   end

   function automatic int rl(int i);
      return i == 1 ? 3 : 1;
   endfunction

   function automatic int mw(int i);
      return i == 0 ? (1 << 18) : 1000;
   endfunction

   function automatic bit isvar(int i);
      return i == 2;
   endfunction

   // Memory read data presented in cycle k: a fixed function of the cycle, so the
   // data a fixed-latency read must return is known at accept time.
   function automatic logic [DW-1:0] hdat(int k, int i, int c);
      return (32'(k) * 32'h9E37_79B1) ^ {8'(i), 8'(c), 16'h0};
   endfunction

   task automatic chk(string nm, int i, int c, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d ch%0d cyc%0d: got %h want %h", nm, i, c, cyc, act, exp);
      end
   endtask

   task automatic drive(int rp, int wp, bit quiet);
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < NC; c++) begin
            int a, r;
            r = int'($urandom_range(9));
            a = r == 1 ? mw(i) - 1 : (r == 0 && i != 0) ? mw(i) + int'($urandom_range(2))
                                                          : int'($urandom_range(mw(i) - 1));
            oor_in[i][c] = a >= mw(i);
            addr[i][c] = AW'(a);
            req[i][c] = int'($urandom_range(99)) < rp;
            we[i][c] = int'($urandom_range(99)) < wp;
            wdata[i][c] = $urandom;
            wmask[i][c] = $urandom;
            mgnt[i][c] = $urandom_range(9) != 0;
            mrdata[i][c] = hdat(cyc, i, c);
            if (quiet) mrvalid[i][c] = 1'b0;
            else if (isvar(i) && owed[i][c] - int'(busy[i][c]) > 0) mrvalid[i][c] = $urandom_range(2) == 0;
            else mrvalid[i][c] = $urandom_range(49) == 0;
         end
      end
   endtask

   task automatic do_reset(int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = 1'b0;
         for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
               sb[i][c].delete();
               fq[i][c].delete();
               owed[i][c] = 0;
               busy[i][c] = 1'b0;
               err_exp[i][c] = 1'b0;
            end
         end
         drive(100, 50, 1'b1);
         #1;
         for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
               chk("rst_gnt", i, c, DW'(gnt[i][c]), '0);
               chk("rst_mem_req", i, c, DW'(mreq[i][c]), '0);
               chk("rst_rdata", i, c, rdata[i][c], '0);
               chk("rst_rerror", i, c, DW'(rerror[i][c]), '0);
               chk("rst_err", i, c, DW'(err[i][c]), '0);
            end
         end
      end
   endtask

   // One cycle: drive, check request-side outputs against the rules, advance the model.
   task automatic step(int rp, int wp);
      @(negedge clk);
      rst_n = 1'b1;
      drive(rp, wp, 1'b0);
      #1;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < NC; c++) begin
            bit fx, cr, pmreq, pgnt, acc, rsp, mem_ok;
            int real_owed;
            exp_t e;
            fx = !isvar(i);
            real_owed = owed[i][c] - int'(busy[i][c]);
            cr = owed[i][c] < MO && (fx || !busy[i][c]);
            pmreq = req[i][c] && !oor_in[i][c] && (we[i][c] || cr);
            pgnt = oor_in[i][c] ? req[i][c] && (we[i][c] || (cr && (fx || owed[i][c] == 0)))
                                : pmreq && mgnt[i][c];
            chk("gnt", i, c, DW'(gnt[i][c]), DW'(pgnt));
            chk("mem_req", i, c, DW'(mreq[i][c]), DW'(pmreq));
            chk("err", i, c, DW'(err[i][c]), DW'(err_exp[i][c]));
            if (pmreq) chk("mem_addr", i, c, DW'(maddr[i][c]), DW'(addr[i][c]));
            if (pmreq && we[i][c]) begin
               chk("mem_we", i, c, DW'(mwe[i][c]), DW'(we[i][c]));
               chk("mem_wdata", i, c, mwdata[i][c], wdata[i][c]);
               chk("mem_wmask", i, c, mwmask[i][c], wmask[i][c]);
            end
            acc = pgnt && !we[i][c];
            if (fx) begin
               rsp = fq[i][c].size() > 0 && fq[i][c][0] == cyc;
               if (rsp) void'(fq[i][c].pop_front());
               if (acc) begin
                  e.due = cyc + rl(i);
                  e.data = oor_in[i][c] ? '0 : hdat(e.due, i, c);
                  e.err = oor_in[i][c] ? RERR_OOR : RERR_NONE;
                  fq[i][c].push_back(e.due);
                  sb[i][c].push_back(e);
               end
            end else begin
               mem_ok = mrvalid[i][c] && real_owed > 0;
               rsp = busy[i][c] || mem_ok;
               if (mrvalid[i][c] && !mem_ok) err_exp[i][c] = 1'b1;
               if (mem_ok) begin
                  e.due = cyc;
                  e.data = hdat(cyc, i, c);
                  e.err = RERR_NONE;
                  sb[i][c].push_back(e);
               end
               if (acc && oor_in[i][c]) begin
                  e.due = cyc + 1;
                  e.data = '0;
                  e.err = RERR_OOR;
                  sb[i][c].push_back(e);
               end
               busy[i][c] = acc && oor_in[i][c];
            end
            owed[i][c] = owed[i][c] + int'(acc) - int'(rsp);
         end
      end
   endtask

   // Response monitor: independent of stimulus, pops the scoreboard whenever a response is due or shown.
   always @(negedge clk) begin
      #2;
      for (int i = 0; i < NI; i++) begin
         for (int c = 0; c < NC; c++) begin
            bit ev;
            exp_t e;
            ev = sb[i][c].size() > 0 && sb[i][c][0].due == cyc;
            chk("rvalid", i, c, DW'(rvalid[i][c]), DW'(ev));
            if (ev) begin
               e = sb[i][c].pop_front();
               if (rvalid[i][c]) begin
                  chk("rdata", i, c, rdata[i][c], e.data);
                  chk("rerror", i, c, DW'(rerror[i][c]), DW'(e.err));
               end
            end
         end
      end
   end

   initial begin
      for (int ph = 0; ph < 3; ph++) begin
         do_reset(ph + 2);
         repeat (1200) step(ph == 1 ? 100 : 60, ph == 1 ? 10 : 30);
         repeat (3) step(100, 0);
      end
      do_reset(2);
      repeat (30) step(40, 20);
      repeat (20) step(0, 0);
      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
